// File: rtl/pq_sorted_array.sv
// pq_sorted_array: sorted-array priority queue with slot 0 as head; each accepted request takes one UPDATE cycle.
// Define PQ_DROP_EN to let an enq on a full queue discard the lowest-priority entry instead of being rejected.

package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_e;
endpackage

module pq_sorted_array #(
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter int DEPTH     = 8,
    parameter int MIN_FIRST = 1,
    localparam int KVW      = KEY_WIDTH + VAL_WIDTH,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enq,
    input  logic           deq,
    input  logic [KVW-1:0] kvi,
    output logic [KVW-1:0] kvo,
    output logic           ovalid,
    output logic           busy,
    output logic           empty,
    output logic           full,
    output logic [CW-1:0]  count,
    output logic           drop
);
    import pq_pkg::*;

    state_e               state_q, state_d;
    logic [KVW-1:0]       slot_q [DEPTH];
    logic [KVW-1:0]       slot_d [DEPTH];
    logic [CW-1:0]        count_q, count_d;
    logic                 op_enq_q, op_deq_q;
    logic [KVW-1:0]       op_kv_q;

    logic                 do_deq, do_enq, accept;
    logic [KVW-1:0]       base [DEPTH];
    logic [CW-1:0]        base_count;
    logic [DEPTH-1:0]     ahead;
    logic [KEY_WIDTH-1:0] new_key;

    // Ties return true so an existing equal key stays ahead of the newcomer (FIFO among equals).
    function automatic logic goes_before(input logic [KEY_WIDTH-1:0] a,
                                         input logic [KEY_WIDTH-1:0] b);
        if (MIN_FIRST != 0) return a <= b;
        else                return a >= b;
    endfunction

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign do_deq = deq && !empty;
`ifdef PQ_DROP_EN
    assign do_enq = enq;
`else
    assign do_enq = enq && (!full || do_deq);
`endif
    assign accept = (state_q == IDLE) && (do_deq || do_enq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == UPDATE);
    end

    // The request is latched at acceptance; the sorted array is rewritten from it one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            op_enq_q <= 1'b0;
            op_deq_q <= 1'b0;
            op_kv_q  <= '0;
        end else if (accept) begin
            op_enq_q <= do_enq;
            op_deq_q <= do_deq;
            op_kv_q  <= kvi;
        end
    end

    assign new_key    = op_kv_q[KVW-1:VAL_WIDTH];
    assign base_count = count_q - CW'(op_deq_q);

    // Head removal shifts everything up one slot; vacated slots are kept at zero.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            base[i] = op_deq_q ? slot_q[i+1] : slot_q[i];
        end
        base[DEPTH-1] = op_deq_q ? '0 : slot_q[DEPTH-1];
    end

    // The array is sorted, so ahead[] is a run of ones followed by zeros; the first zero is the insert slot.
    always_comb begin
        ahead = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ahead[i] = (CW'(i) < base_count) && goes_before(base[i][KVW-1:VAL_WIDTH], new_key);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        count_d = count_q;
        if (state_q == UPDATE) begin
            if (!op_enq_q) begin
                for (int i = 0; i < DEPTH; i++) begin
                    slot_d[i] = base[i];
                end
                count_d = base_count;
            end else begin
                // On a full array the entry pushed past the last slot falls off: the old tail or kvi itself.
                slot_d[0] = ahead[0] ? base[0] : op_kv_q;
                for (int i = 1; i < DEPTH; i++) begin
                    if (ahead[i])        slot_d[i] = base[i];
                    else if (ahead[i-1]) slot_d[i] = op_kv_q;
                    else                 slot_d[i] = base[i-1];
                end
                count_d = (base_count == CW'(DEPTH)) ? base_count : base_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the slot array is a flop-based register file, so it is cleared by reset like any other state.
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
        end
    end

`ifdef PQ_DROP_EN
    logic drop_q, drop_d;

    assign drop_d = (state_q == UPDATE) && op_enq_q && (base_count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_q <= 1'b0;
        else      drop_q <= drop_d;
    end

    assign drop = drop_q;
`else
    assign drop = 1'b0;
`endif

    assign kvo    = slot_q[0];
    assign ovalid = !empty;
    assign count  = count_q;

endmodule

// File: tb/tb_pq_sorted_array.sv
// Self-checking bench for pq_sorted_array: directed vector table, corner sequences, and a random run
// against a keyed/arrival-order reference model. Expectations follow PQ_DROP_EN when it is defined.

module tb_pq_sorted_array;

`ifdef PQ_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        enq, deq;
    logic [15:0] kvi, kvo;
    logic        ovalid, busy, empty, full, drop;
    logic [2:0]  count;

    logic        enq2, deq2;
    logic [15:0] kvi2, kvo2;
    logic        ovalid2, busy2, empty2, full2, drop2;
    logic [2:0]  count2;

    int n_checks = 0;
    int n_fail   = 0;

    pq_sorted_array #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(DEPTH), .MIN_FIRST(1)) dut (
        .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo),
        .ovalid(ovalid), .busy(busy), .empty(empty), .full(full), .count(count), .drop(drop)
    );

    pq_sorted_array #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(DEPTH), .MIN_FIRST(0)) dut_max (
        .clk(clk), .rst(rst), .enq(enq2), .deq(deq2), .kvi(kvi2), .kvo(kvo2),
        .ovalid(ovalid2), .busy(busy2), .empty(empty2), .full(full2), .count(count2), .drop(drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request held for a single sample edge; returns after the update edge when the DUT went busy.
    task automatic drive_op(input bit e, input bit d, input logic [15:0] kv, output bit seen_busy);
        @(negedge clk);
        enq = e;
        deq = d;
        kvi = kv;
        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        seen_busy = busy;
        if (busy) @(negedge clk);
    endtask

    typedef struct {
        bit          enq;
        bit          deq;
        logic [15:0] kv;
        bit          exp_busy;
        logic [15:0] exp_kvo;
        int          exp_count;
        bit          exp_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit e, input bit d, input logic [15:0] kv, input bit b,
                                input logic [15:0] ko, input int c, input bit dr);
        vec_t v;
        v.enq = e; v.deq = d; v.kv = kv; v.exp_busy = b;
        v.exp_kvo = ko; v.exp_count = c; v.exp_drop = dr;
        vecs.push_back(v);
    endfunction

    // Reference model: unordered bag of entries tagged with arrival number; priority is (key, arrival).
    int mkey[$], mval[$], mseq[$];
    int seq_ctr = 0;

    function automatic int best_idx();
        int b = 0;
        for (int i = 1; i < mkey.size(); i++)
            if (mkey[i] < mkey[b] || (mkey[i] == mkey[b] && mseq[i] < mseq[b])) b = i;
        return b;
    endfunction

    function automatic int worst_idx();
        int w = 0;
        for (int i = 1; i < mkey.size(); i++)
            if (mkey[i] > mkey[w] || (mkey[i] == mkey[w] && mseq[i] > mseq[w])) w = i;
        return w;
    endfunction

    function automatic void model_push(input logic [15:0] kv);
        mkey.push_back(int'(kv[15:8]));
        mval.push_back(int'(kv[7:0]));
        mseq.push_back(seq_ctr);
        seq_ctr++;
    endfunction

    function automatic void model_del(input int idx);
        mkey.delete(idx);
        mval.delete(idx);
        mseq.delete(idx);
    endfunction

    function automatic void model_apply(input bit e, input bit d, input logic [15:0] kv,
                                        output bit exp_busy, output bit exp_drop);
        int  n  = mkey.size();
        bit  dd = d && (n > 0);
        bit  de = e && (n < DEPTH || dd || DROP_EN);
        int  w;
        exp_busy = dd || de;
        exp_drop = 1'b0;
        if (dd) model_del(best_idx());
        if (de) begin
            if (mkey.size() == DEPTH) begin
                exp_drop = 1'b1;
                w = worst_idx();
                if (int'(kv[15:8]) < mkey[w]) begin
                    model_del(w);
                    model_push(kv);
                end
            end else begin
                model_push(kv);
            end
        end
    endfunction

    function automatic logic [15:0] model_kvo();
        int b;
        if (mkey.size() == 0) return 16'h0000;
        b = best_idx();
        return {mkey[b][7:0], mval[b][7:0]};
    endfunction

    initial begin
        bit          s;
        bit          eb, ed;
        bit          re, rd;
        logic [15:0] rkv;
        int          k2[3];
        int          ord2[3];

        rst = 1'b0; enq = 1'b0; deq = 1'b0; kvi = '0;
        enq2 = 1'b0; deq2 = 1'b0; kvi2 = '0;

        // enq, deq, kv, busy, kvo, count, drop
        add(1, 0, 16'h0503, 1, 16'h0503, 1, 0);
        add(1, 0, 16'h0A01, 1, 16'h0503, 2, 0);
        add(1, 0, 16'h0304, 1, 16'h0304, 3, 0);
        add(1, 0, 16'h140A, 1, 16'h0304, 4, 0);
        add(0, 1, 16'h0000, 1, 16'h0503, 3, 0);
        add(0, 1, 16'h0000, 1, 16'h0A01, 2, 0);
        add(0, 1, 16'h0000, 1, 16'h140A, 1, 0);
        add(0, 1, 16'h0000, 1, 16'h0000, 0, 0);
        add(0, 1, 16'h0000, 0, 16'h0000, 0, 0);
        add(1, 0, 16'h0701, 1, 16'h0701, 1, 0);
        add(1, 0, 16'h0702, 1, 16'h0701, 2, 0);
        add(1, 0, 16'h0703, 1, 16'h0701, 3, 0);
        add(0, 1, 16'h0000, 1, 16'h0702, 2, 0);
        add(0, 1, 16'h0000, 1, 16'h0703, 1, 0);
        add(0, 1, 16'h0000, 1, 16'h0000, 0, 0);
        add(1, 1, 16'h0606, 1, 16'h0606, 1, 0);
        add(0, 1, 16'h0000, 1, 16'h0000, 0, 0);
        add(1, 0, 16'h0C00, 1, 16'h0C00, 1, 0);
        add(1, 0, 16'h0200, 1, 16'h0200, 2, 0);
        add(1, 0, 16'h1B00, 1, 16'h0200, 3, 0);
        add(1, 0, 16'h0800, 1, 16'h0200, 4, 0);
        add(1, 1, 16'h0909, 1, 16'h0800, 4, 0);
`ifdef PQ_DROP_EN
        add(1, 0, 16'h010B, 1, 16'h010B, 4, 1);
        add(1, 0, 16'h1E00, 1, 16'h010B, 4, 1);
        add(0, 1, 16'h0000, 1, 16'h0800, 3, 0);
        add(0, 1, 16'h0000, 1, 16'h0909, 2, 0);
        add(0, 1, 16'h0000, 1, 16'h0C00, 1, 0);
        add(0, 1, 16'h0000, 1, 16'h0000, 0, 0);
`else
        add(1, 0, 16'h010B, 0, 16'h0800, 4, 0);
        add(1, 0, 16'h1E00, 0, 16'h0800, 4, 0);
        add(0, 1, 16'h0000, 1, 16'h0909, 3, 0);
        add(0, 1, 16'h0000, 1, 16'h0C00, 2, 0);
        add(0, 1, 16'h0000, 1, 16'h1B00, 1, 0);
        add(0, 1, 16'h0000, 1, 16'h0000, 0, 0);
`endif

        repeat (3) @(negedge clk);
        check("reset count", 32'(count), 0);
        check("reset empty", 32'(empty), 1);
        check("reset full", 32'(full), 0);
        check("reset ovalid", 32'(ovalid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset drop", 32'(drop), 0);
        check("reset kvo", 32'(kvo), 0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_op(vecs[i].enq, vecs[i].deq, vecs[i].kv, s);
            check($sformatf("vec%0d busy", i), 32'(s), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d kvo", i), 32'(kvo), 32'(vecs[i].exp_kvo));
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].exp_count == DEPTH));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_count == 0));
            check($sformatf("vec%0d ovalid", i), 32'(ovalid), 32'(vecs[i].exp_count != 0));
            check($sformatf("vec%0d drop", i), 32'(drop), 32'(vecs[i].exp_drop));
            if (vecs[i].exp_drop) begin
                @(negedge clk);
                check($sformatf("vec%0d drop_clear", i), 32'(drop), 0);
            end
        end

        // enq held across the UPDATE cycle: the second sample must be ignored.
        @(negedge clk);
        enq = 1'b1; kvi = 16'h1122;
        @(negedge clk);
        check("hold busy_k", 32'(busy), 1);
        @(negedge clk);
        enq = 1'b0;
        check("hold busy_k1", 32'(busy), 0);
        check("hold count_k1", 32'(count), 1);
        @(negedge clk);
        check("hold count_after", 32'(count), 1);
        check("hold busy_after", 32'(busy), 0);
        drive_op(0, 1, 16'h0000, s);
        check("hold drain", 32'(count), 0);

        // Reset asserted in UPDATE aborts the write; first request after release is taken at once.
        drive_op(1, 0, 16'h4001, s);
        @(negedge clk);
        enq = 1'b1; kvi = 16'h3002;
        @(negedge clk);
        enq = 1'b0;
        check("rstupd busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("rstupd count", 32'(count), 0);
        check("rstupd kvo", 32'(kvo), 0);
        check("rstupd busy_now", 32'(busy), 0);
        check("rstupd ovalid", 32'(ovalid), 0);
        check("rstupd empty", 32'(empty), 1);
        check("rstupd full", 32'(full), 0);
        check("rstupd drop", 32'(drop), 0);
        @(negedge clk);
        check("rstupd held_count", 32'(count), 0);
        check("rstupd held_kvo", 32'(kvo), 0);
        rst = 1'b1; enq = 1'b1; kvi = 16'h5005;
        @(negedge clk);
        enq = 1'b0;
        check("post_rst busy", 32'(busy), 1);
        @(negedge clk);
        check("post_rst kvo", 32'(kvo), 32'h5005);
        check("post_rst count", 32'(count), 1);
        drive_op(0, 1, 16'h0000, s);
        check("post_rst drain", 32'(count), 0);

        // Largest-key-first instance.
        k2   = '{5, 10, 3};
        ord2 = '{10, 5, 3};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enq2 = 1'b1; kvi2 = {k2[i][7:0], 8'(i)};
            @(negedge clk);
            enq2 = 1'b0;
            @(negedge clk);
        end
        check("max count", 32'(count2), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("max head%0d", i), 32'(kvo2[15:8]), 32'(ord2[i]));
            @(negedge clk);
            deq2 = 1'b1;
            @(negedge clk);
            deq2 = 1'b0;
            @(negedge clk);
        end
        check("max empty", 32'(empty2), 1);

        // Random traffic against the reference model; small key range forces many ties.
        mkey.delete(); mval.delete(); mseq.delete();
        for (int i = 0; i < 300; i++) begin
            re  = ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 9) < 4);
            rkv = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            model_apply(re, rd, rkv, eb, ed);
            drive_op(re, rd, rkv, s);
            check($sformatf("rnd%0d busy", i), 32'(s), 32'(eb));
            check($sformatf("rnd%0d kvo", i), 32'(kvo), 32'(model_kvo()));
            check($sformatf("rnd%0d count", i), 32'(count), 32'(mkey.size()));
            check($sformatf("rnd%0d drop", i), 32'(drop), 32'(ed));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pq_sorted_array.md
PQ_SORTED_ARRAY -- requirements
Module: pq_sorted_array

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter KEY_WIDTH, default pq_pkg KEY_WIDTH, SHALL set the key field width.
REQ-003 Parameter VAL_WIDTH, default pq_pkg VAL_WIDTH, SHALL set the value field width.
REQ-004 Parameter DEPTH, default 8, SHALL set the entry count; legal range is 2..64.
REQ-005 Parameter MIN_FIRST, default 1, SHALL select priority: 1 means smallest key first, 0 means largest key first.
REQ-006 clk  in  1  SHALL be the single rising-edge clock.
REQ-007 rst  in  1  SHALL be the asynchronous active-low reset.
REQ-008 enq  in  1  SHALL request insertion of kvi.
REQ-009 deq  in  1  SHALL request removal of the head entry.
REQ-010 kvi  in  KEY_WIDTH+VAL_WIDTH  SHALL carry the insert data as {key,val}.
REQ-011 kvo  out  KEY_WIDTH+VAL_WIDTH  SHALL carry the head entry as {key,val}.
REQ-012 ovalid  out  1  SHALL be high when kvo holds a valid entry.
REQ-013 busy  out  1  SHALL be high while an accepted operation is being applied.
REQ-014 empty / full  out  1 each  SHALL flag count==0 and count==DEPTH.
REQ-015 count  out  $clog2(DEPTH+1)  SHALL give the number of stored entries.
REQ-016 drop  out  1  SHALL pulse for one cycle when an entry is discarded (only under PQ_DROP_EN).

Function
REQ-017 Entries SHALL be held sorted, with slot 0 as the head; kvo SHALL equal slot 0 and ovalid SHALL equal !empty.
REQ-018 Equal keys SHALL dequeue in arrival order: a new entry goes after all existing entries with an equal key.
REQ-019 The FSM SHALL have exactly two states, IDLE and UPDATE; busy SHALL be 1 only in UPDATE.
REQ-020 In IDLE, an accepted request sampled at edge k SHALL move the FSM to UPDATE, and storage, count and kvo SHALL change at edge k+1.
REQ-021 The FSM SHALL return to IDLE at edge k+1.
REQ-022 Requests sampled in UPDATE SHALL be ignored; the requester holds enq/deq for one cycle and then waits for !busy.
REQ-023 deq alone when empty SHALL be ignored: no state change, and busy stays 0.
REQ-024 enq alone when full, without PQ_DROP_EN, SHALL be rejected: no state change, and busy stays 0.
REQ-025 enq together with deq SHALL act as a replace: the head is removed and kvi is inserted in one UPDATE, count is unchanged, and this is legal when full.
REQ-026 enq together with deq when empty SHALL act as a plain enq.
REQ-027 Key comparison SHALL be unsigned over KEY_WIDTH bits; the value field SHALL never affect ordering.

Reset
REQ-028 While rst=0, the block SHALL force: state IDLE, count=0, empty=1, full=0, ovalid=0, busy=0, drop=0, kvo=0, all slots cleared.
REQ-029 Reset asserted during UPDATE SHALL abort the operation with no partial write surviving.
REQ-030 The first request SHALL be accepted on the first rising edge after rst returns to 1.

Configuration
REQ-031 Macro PQ_DROP_EN SHALL compile in drop-on-full behaviour.
REQ-032 With PQ_DROP_EN, enq alone when full SHALL be accepted (busy for one cycle). If the kvi key is strictly higher priority than the tail entry, the tail SHALL be discarded and kvi inserted; otherwise kvi SHALL be discarded. drop SHALL pulse at edge k+1 in both cases, and count SHALL stay DEPTH.
REQ-033 Without PQ_DROP_EN, the drop output SHALL be tied to 0 and REQ-024 SHALL apply.

Verification (DEPTH=4, MIN_FIRST=1, KEY_WIDTH=VAL_WIDTH=8 unless stated)
REQ-034 Enq (5,3),(10,1),(3,4),(20,10) -> after each op the head is (5,3),(5,3),(3,4),(3,4); count=4, full=1; repeated deq yields keys 3,5,10,20, then empty=1.
REQ-035 Enq (7,1),(7,2),(7,3), then deq x3 -> vals 1,2,3 in that order.
REQ-036 With the queue holding keys 2,8,12,27, enq+deq (9,9) -> head 8, count 4, contents 8,9,12,27.
REQ-037 Full queue plus enq (1,11): without PQ_DROP_EN, busy stays 0 and the contents are unchanged. With PQ_DROP_EN, the 27 entry is dropped, drop=1 for one cycle, and the head is (1,11). Enq (30,0) when full with PQ_DROP_EN -> drop pulses and the contents are unchanged.
REQ-038 Deq on empty -> busy 0, count 0, ovalid 0. Rst=0 during an UPDATE cycle -> all outputs at reset values on the next edge.
REQ-039 MIN_FIRST=0, enq keys 5,10,3 -> deq order 10,5,3.
